// File: rtl/data_split.sv
// Byte-to-beat splitter: queues {mode, byte} entries and emits either the whole byte or two zero-extended nibbles.
// Latency: first beat is valid one edge after the entry reaches the FIFO head; one beat per cycle while data_o_rdy holds high.
// Backpressure: data_o/data_en hold while stalled; data_in_rdy drops when the FIFO is full or start is low. Macro DATA_SPLIT_LSN_FIRST_EN selects low-nibble-first order.
module data_split #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       byte_mode,
    input  logic [7:0] data_in,
    input  logic       data_in_en,
    output logic       data_in_rdy,
    output logic [7:0] data_o,
    output logic       data_en,
    input  logic       data_o_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [0:0]    ST_HI    = 1'b0;
    localparam logic [0:0]    ST_LO    = 1'b1;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic          live;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [8:0]    head;
    logic [8:0]    nxt;

`ifdef DATA_SPLIT_LSN_FIRST_EN
    function automatic logic [3:0] nib_first(input logic [7:0] d);
        return d[3:0];
    endfunction
    function automatic logic [3:0] nib_second(input logic [7:0] d);
        return d[7:4];
    endfunction
`else
    function automatic logic [3:0] nib_first(input logic [7:0] d);
        return d[7:4];
    endfunction
    function automatic logic [3:0] nib_second(input logic [7:0] d);
        return d[3:0];
    endfunction
`endif

    function automatic logic [7:0] first_beat(input logic [8:0] e);
        return e[8] ? e[7:0] : {4'h0, nib_first(e[7:0])};
    endfunction

    assign rd_nxt      = rd_ptr + PTR_ONE;
    assign head        = mem[rd_ptr];
    assign nxt         = mem[rd_nxt];
    assign data_in_rdy = live & start & (count < CNT_FULL);
    assign push        = data_in_en & data_in_rdy;
    assign xfer        = data_en & data_o_rdy;
    // An entry leaves the FIFO only once its last beat has been taken.
    assign pop         = xfer & ((state == ST_LO) | head[8]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {byte_mode, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state   <= ST_HI;
            live    <= 1'b0;
            data_o  <= 8'h00;
            data_en <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (xfer && (state == ST_HI) && !head[8]) begin
                state  <= ST_LO;
                data_o <= {4'h0, nib_second(head[7:0])};
            end else if (pop) begin
                // Chain straight into the following entry to avoid a bubble.
                state <= ST_HI;
                if (count > CNT_ONE) begin
                    data_en <= 1'b1;
                    data_o  <= first_beat(nxt);
                end else begin
                    data_en <= 1'b0;
                    data_o  <= 8'h00;
                end
            end else if (!data_en && (count != '0)) begin
                state   <= ST_HI;
                data_en <= 1'b1;
                data_o  <= first_beat(head);
            end
        end
    end

endmodule

// File: tb/tb_data_split.sv
// Directed bench for data_split: byte/nibble modes, mixed stream, backpressure, reset in LO, start drop.
module tb_data_split;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic       byte_mode = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_en = 1'b0;
    logic       data_in_rdy;
    logic [7:0] data_o;
    logic       data_en;
    logic       data_o_rdy = 1'b1;

    always #5 clk = ~clk;

    data_split #(.DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_mode(byte_mode),
        .data_in(data_in),
        .data_in_en(data_in_en),
        .data_in_rdy(data_in_rdy),
        .data_o(data_o),
        .data_en(data_en),
        .data_o_rdy(data_o_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifdef DATA_SPLIT_LSN_FIRST_EN
    function automatic logic [7:0] nf(input logic [7:0] d); return {4'h0, d[3:0]}; endfunction
    function automatic logic [7:0] ns(input logic [7:0] d); return {4'h0, d[7:4]}; endfunction
`else
    function automatic logic [7:0] nf(input logic [7:0] d); return {4'h0, d[7:4]}; endfunction
    function automatic logic [7:0] ns(input logic [7:0] d); return {4'h0, d[3:0]}; endfunction
`endif

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         idle_viol = 0;
    int         hold_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_o = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (data_en !== 1'b1 || data_o !== prev_o)) hold_viol++;
            if (data_en && data_o_rdy) got_q.push_back(data_o);
            if (!data_en && data_o !== 8'h00) idle_viol++;
            prev_stall = data_en && !data_o_rdy;
            prev_o     = data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic m);
        bit ok = 0;
        data_in    = d;
        byte_mode  = m;
        data_in_en = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (data_in_rdy) ok = 1;
            tick();
        end
        data_in_en = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic expb(input logic [7:0] d, input logic m);
        if (m) begin
            exp_q.push_back(d);
        end else begin
            exp_q.push_back(nf(d));
            exp_q.push_back(ns(d));
        end
    endtask

    task automatic drain_check(input string tag);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (got_q.size() >= exp_q.size() && !data_en) done = 1;
            else tick();
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tick();
        tick();
        check("rst_en", data_en, 0);
        check("rst_o", data_o, 8'h00);
        check("rst_rdy", data_in_rdy, 0);
        reset = 1'b0;
        tick();
        check("rdy_after_rst", data_in_rdy, 1);

        // Byte mode: A5 appears one edge after acceptance, single beat.
        got_q.delete();
        push(8'hA5, 1'b1);
        check("a5_en_at_E", data_en, 0);
        tick();
        check("a5_en", data_en, 1);
        check("a5_o", data_o, 8'hA5);
        tick();
        check("a5_en_off", data_en, 0);
        check("a5_o_off", data_o, 8'h00);
        expb(8'hA5, 1'b1);
        drain_check("a5_stream");

        // Nibble mode; mode input flips after acceptance and must be ignored.
        push(8'h3C, 1'b0);
        byte_mode = 1'b1;
        tick();
        check("3c_beat1", data_o, nf(8'h3C));
        tick();
        check("3c_beat2", data_o, ns(8'h3C));
        check("3c_beat2_en", data_en, 1);
        tick();
        check("3c_done_en", data_en, 0);
        expb(8'h3C, 1'b0);
        drain_check("3c_stream");

        // Mixed modes, back-to-back.
        push(8'h12, 1'b0);
        push(8'h34, 1'b1);
        push(8'h56, 1'b0);
        expb(8'h12, 1'b0);
        expb(8'h34, 1'b1);
        expb(8'h56, 1'b0);
        drain_check("mixed");

        // Backpressure: four entries fill the FIFO, fifth waits.
        data_o_rdy = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h3A, 1'b0);
        push(8'h44, 1'b1);
        check("bp_rdy_full", data_in_rdy, 0);
        check("bp_en", data_en, 1);
        check("bp_o", data_o, 8'h11);
        data_in = 8'h55; byte_mode = 1'b1; data_in_en = 1'b1;
        tick(); tick(); tick();
        check("bp_rdy_still", data_in_rdy, 0);
        check("bp_hold_o", data_o, 8'h11);
        data_o_rdy = 1'b1;
        push(8'h55, 1'b1);
        expb(8'h11, 1'b1);
        expb(8'h22, 1'b1);
        expb(8'h3A, 1'b0);
        expb(8'h44, 1'b1);
        expb(8'h55, 1'b1);
        drain_check("bp");

        // Reset while the second nibble is pending.
        push(8'h9E, 1'b0);
        tick();
        check("lo_beat1", data_o, nf(8'h9E));
        tick();
        check("lo_beat2_shown", data_o, ns(8'h9E));
        reset = 1'b1;
        tick();
        check("lo_rst_en", data_en, 0);
        check("lo_rst_o", data_o, 8'h00);
        check("lo_rst_rdy", data_in_rdy, 0);
        reset = 1'b0;
        push(8'h77, 1'b1);
        exp_q.push_back(nf(8'h9E));
        expb(8'h77, 1'b1);
        drain_check("lo_rst");

        // Start drop: acceptance stops, queued nibbles still drain.
        data_o_rdy = 1'b0;
        push(8'h5A, 1'b0);
        push(8'hC3, 1'b0);
        start = 1'b0;
        #1;
        check("sd_rdy", data_in_rdy, 0);
        data_o_rdy = 1'b1;
        expb(8'h5A, 1'b0);
        expb(8'hC3, 1'b0);
        drain_check("sd");
        check("sd_rdy_after", data_in_rdy, 0);
        start = 1'b1;

        check("idle_zero", idle_viol, 0);
        check("stall_hold", hold_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_split.md
DATA_SPLIT -- requirements
Module: data_split

Interface
REQ-001 SHALL have parameter DEPTH, default 4, input byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  acceptance enable; low blocks new input.
REQ-005 SHALL have port byte  input  1  mode tag for the incoming byte: 1 = emit whole byte, 0 = emit two nibbles.
REQ-006 SHALL have port data_in  input  8  byte from upstream.
REQ-007 SHALL have port data_in_en  input  1  upstream valid.
REQ-008 SHALL have port data_in_rdy  output  1  ready to accept a byte.
REQ-009 SHALL have port data_o  output  8  output beat; nibble in [3:0], [7:4]=0 in nibble mode.
REQ-010 SHALL have port data_en  output  1  output valid.
REQ-011 SHALL have port data_o_rdy  input  1  downstream ready.

Function
REQ-012 SHALL accept a byte on an edge where data_in_en && data_in_rdy, storing {byte, data_in} as one 9-bit FIFO entry.
REQ-013 SHALL drive data_in_rdy = start && (FIFO occupancy < DEPTH); no same-cycle bypass when full, even if a pop occurs.
REQ-014 SHALL track occupancy with a counter of width log2(DEPTH)+1 and wrapping read/write pointers; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-015 SHALL transfer an output beat on an edge where data_en && data_o_rdy.
REQ-016 SHALL hold data_o and data_en stable while data_en && !data_o_rdy.
REQ-017 SHALL drive data_o = 8'h00 whenever data_en is low.
REQ-018 SHALL implement output state machine HI/LO: HI = next beat is first (or only) beat of head entry; LO = second nibble pending.
REQ-019 In HI with head tag byte=1, SHALL present data_o = full byte; on transfer pop the entry, remain in HI.
REQ-020 In HI with head tag byte=0, SHALL present first nibble; on transfer go to LO without popping.
REQ-021 In LO, SHALL present second nibble of the head entry; on transfer pop the entry and return to HI.
REQ-022 SHALL load the output register one edge after an entry becomes head: byte accepted on edge E into an empty FIFO with idle output yields data_en high after edge E+1.
REQ-023 With data_o_rdy held high, SHALL sustain one beat per cycle across consecutive entries, including LO-to-next-HI.
REQ-024 SHALL use the mode tag latched at acceptance; changes on byte after acceptance have no effect on that entry.
REQ-025 When start falls, SHALL stop accepting but continue draining FIFO and any pending LO nibble; no data lost.
REQ-026 When FIFO empties after the final transfer, SHALL deassert data_en on that edge.

Reset
REQ-027 On reset high at a clock edge, SHALL set data_o=8'h00, data_en=0, data_in_rdy=0, occupancy=0, pointers=0, state=HI.
REQ-028 Reset asserted mid-byte (state LO or FIFO non-empty) SHALL discard all stored data; first beat after reset comes from first byte accepted after reset.
REQ-029 data_in_rdy SHALL rise on the first edge after reset deasserts if start is high.

Configuration
REQ-030 Macro DATA_SPLIT_LSN_FIRST_EN SHALL select nibble order.
REQ-031 Without DATA_SPLIT_LSN_FIRST_EN: first nibble = data_in[7:4], second = data_in[3:0] (matches the nibble packer order).
REQ-032 With DATA_SPLIT_LSN_FIRST_EN: first nibble = data_in[3:0], second = data_in[7:4]; byte-mode output unchanged.

Verification
REQ-033 Byte mode: push 8'hA5 (byte=1), data_o_rdy=1 -> data_en one beat, data_o=8'hA5 after edge E+1.
REQ-034 Nibble mode, macro off: push 8'h3C (byte=0) -> beats 8'h03 then 8'h0C on consecutive cycles; macro on -> 8'h0C then 8'h03.
REQ-035 Backpressure: data_o_rdy=0, push 5 bytes with DEPTH=4 -> data_in_rdy low after 4 accepted; data_o held; release -> all accepted bytes emitted in order.
REQ-036 Mixed modes: push 8'h12 (byte=0), 8'h34 (byte=1), 8'h56 (byte=0) -> beats 01,02,34,05,06.
REQ-037 Reset in LO: push 8'h9E nibble mode, reset after first nibble transfer -> data_en=0, data_o=0, no 8'h0E beat; next push 8'h77 byte=1 -> 8'h77.
REQ-038 start drop: push 2 nibble bytes, drop start -> data_in_rdy=0, all 4 beats still emitted.
